// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Optional signed operation is enabled with the SEQ_MULT_SIGNED_EN macro.
package seq_mult_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned MAX_WIDTH     = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // Returns the upper or lower width-bit half of a product, zero-padded to MAX_WIDTH.
    function automatic logic [MAX_WIDTH-1:0] half_select(
        input logic [2*MAX_WIDTH-1:0] prod,
        input int unsigned            width,
        input logic                   hi_sel
    );
        logic [2*MAX_WIDTH-1:0] shifted;
        logic [2*MAX_WIDTH-1:0] mask;
        shifted = hi_sel ? (prod >> width) : prod;
        mask    = (64'd1 << width) - 64'd1;
        return MAX_WIDTH'(shifted & mask);
    endfunction

endpackage

// File: rtl/seq_mult_acc.sv
// Shift-add datapath for seq_mult: 2*WIDTH accumulator, shifting operands
// and iteration counter; flags the final iteration to the control FSM.
module seq_mult_acc
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 step,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic [2*WIDTH-1:0]   acc_next,
    output logic                 done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand_sh;
    logic [WIDTH-1:0]   mplier_sh;
    logic [CNT_W-1:0]   cnt;

    // mcand_sh always equals the multiplicand shifted left by cnt.
    always_comb begin
        acc_next = acc + (mplier_sh[0] ? mcand_sh : '0);
        done     = step && (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            mcand_sh  <= '0;
            mplier_sh <= '0;
            cnt       <= '0;
        end else if (start) begin
            acc       <= '0;
            mcand_sh  <= {{WIDTH{1'b0}}, mcand};
            mplier_sh <= mplier;
            cnt       <= '0;
        end else if (step) begin
            acc       <= acc_next;
            mcand_sh  <= mcand_sh << 1;
            mplier_sh <= mplier_sh >> 1;
            cnt       <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_mult.sv
// Multi-cycle shift-add multiplier with valid/ready handshakes on both sides.
// Define SEQ_MULT_SIGNED_EN to honour signed_mode (sign-magnitude operation).
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 hi_sel,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     out_half
);

    state_t             state;
    logic               start;
    logic               step;
    logic               acc_done;
    logic               hi_q;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] result;

    assign in_ready = (state == IDLE);
    assign start    = in_valid && (state == IDLE);
    assign step     = (state == BUSY);

`ifdef SEQ_MULT_SIGNED_EN
    logic sign_a;
    logic sign_b;
    logic neg_q;

    // Magnitudes fit WIDTH unsigned bits, including -2^(WIDTH-1).
    always_comb begin
        sign_a = signed_mode && a[WIDTH-1];
        sign_b = signed_mode && b[WIDTH-1];
        mag_a  = sign_a ? -a : a;
        mag_b  = sign_b ? -b : b;
    end

    assign result = neg_q ? -acc_next : acc_next;
`else
    logic unused_signed_mode;

    assign unused_signed_mode = signed_mode;
    assign mag_a              = a;
    assign mag_b              = b;
    assign result             = acc_next;
`endif

    seq_mult_acc #(
        .WIDTH(WIDTH)
    ) u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .step     (step),
        .mcand    (mag_a),
        .mplier   (mag_b),
        .acc_next (acc_next),
        .done     (acc_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            product   <= '0;
            out_half  <= '0;
            hi_q      <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        hi_q  <= hi_sel;
`ifdef SEQ_MULT_SIGNED_EN
                        neg_q <= sign_a ^ sign_b;
`endif
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (acc_done) begin
                        product   <= result;
                        out_half  <= WIDTH'(half_select((2*MAX_WIDTH)'(result), WIDTH, hi_q));
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult.sv
// Directed-vector and randomized scoreboard bench for seq_mult at WIDTH=8.
// Honours SEQ_MULT_SIGNED_EN so expectations follow the build configuration.
module tb_seq_mult;

    localparam int unsigned W = 8;
`ifdef SEQ_MULT_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           hi_sel;
    logic           signed_mode;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;
    logic [W-1:0]   out_half;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        hi;
        logic        sm;
        logic [15:0] prod;
        logic [7:0]  half;
    } vec_t;

    typedef struct {
        logic [15:0] prod;
        logic [7:0]  half;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];

    seq_mult #(
        .WIDTH(W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .hi_sel      (hi_sel),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .product     (product),
        .out_half    (out_half)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_prod(input logic [7:0] x, input logic [7:0] y, input logic sm);
        int px;
        int py;
        if (sm && SIGNED_BUILD) begin
            px = int'($signed(x));
            py = int'($signed(y));
        end else begin
            px = int'(x);
            py = int'(y);
        end
        return 16'(px * py);
    endfunction

    // Waits for idle, presents operands for the accepting edge, then scrambles inputs.
    task automatic start_txn(input logic [7:0] ta, input logic [7:0] tb_v, input logic th, input logic ts);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #2;
            w++;
        end
        if (w >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: in_ready stayed 0 for %0d cycles, required 1", w);
        end
        a = ta; b = tb_v; hi_sel = th; signed_mode = ts; in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0; a = ~ta; b = tb_v ^ 8'h5A; hi_sel = ~th; signed_mode = ~ts;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #2;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int sent;
        int n_acc;
        int n_hs;
        int cyc;
        logic        hold_v;
        logic [15:0] hold_p;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic        rh;
        logic        rs;
        logic [15:0] rp;
        exp_t        e;

        vecs[0] = '{8'h0F, 8'h0F, 1'b0, 1'b0, 16'h00E1, 8'hE1};
        vecs[1] = '{8'h0F, 8'h0F, 1'b1, 1'b0, 16'h00E1, 8'h00};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 16'hFE01, 8'hFE};
        vecs[3] = '{8'h00, 8'hC8, 1'b0, 1'b0, 16'h0000, 8'h00};
`ifdef SEQ_MULT_SIGNED_EN
        vecs[4] = '{8'hFD, 8'h05, 1'b0, 1'b1, 16'hFFF1, 8'hF1};
        vecs[5] = '{8'h80, 8'h80, 1'b1, 1'b1, 16'h4000, 8'h40};
        vecs[6] = '{8'h80, 8'h7F, 1'b1, 1'b1, 16'hC080, 8'hC0};
`else
        vecs[4] = '{8'hFD, 8'h05, 1'b0, 1'b1, 16'h04F1, 8'hF1};
        vecs[5] = '{8'h80, 8'h80, 1'b1, 1'b1, 16'h4000, 8'h40};
        vecs[6] = '{8'h80, 8'h7F, 1'b1, 1'b1, 16'h3F80, 8'h3F};
`endif

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; hi_sel = 1'b0; signed_mode = 1'b0;
        #3;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_product", 32'(product), 32'd0);
        chk("reset_out_half", 32'(out_half), 32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk); #2;

        for (int i = 0; i < 7; i++) begin
            out_ready = 1'b1;
            start_txn(vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].sm);
            chk($sformatf("vec%0d_busy_in_ready", i), 32'(in_ready), 32'd0);
            wait_result(lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
            chk($sformatf("vec%0d_product", i), 32'(product), 32'(vecs[i].prod));
            chk($sformatf("vec%0d_out_half", i), 32'(out_half), 32'(vecs[i].half));
            @(posedge clk); #2;
            chk($sformatf("vec%0d_post_valid", i), 32'(out_valid), 32'd0);
        end

        // Backpressure: hold result for 5 cycles while a new operand waits.
        out_ready = 1'b0;
        start_txn(8'd200, 8'd3, 1'b0, 1'b0);
        wait_result(lat);
        chk("bp_latency", 32'(lat), 32'd8);
        chk("bp_product", 32'(product), 32'h0258);
        for (int i = 0; i < 5; i++) begin
            a = 8'd12; b = 8'd10; hi_sel = 1'b0; signed_mode = 1'b0; in_valid = 1'b1;
            @(posedge clk); #2;
            chk($sformatf("bp_hold_product_%0d", i), 32'(product), 32'h0258);
            chk($sformatf("bp_hold_half_%0d", i), 32'(out_half), 32'h58);
            chk($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd0);
            chk($sformatf("bp_out_valid_%0d", i), 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #2;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #2;
        chk("bp_next_accepted", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        wait_result(lat);
        chk("bp_next_latency", 32'(lat), 32'd8);
        chk("bp_next_product", 32'(product), 32'h0078);
        @(posedge clk); #2;

        // Reset asserted on the 4th BUSY edge discards the operation.
        start_txn(8'd100, 8'd3, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
        end
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_product", 32'(product), 32'd0);
        chk("rst_mid_out_half", 32'(out_half), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #2;
        start_txn(8'd7, 8'd9, 1'b0, 1'b0);
        wait_result(lat);
        chk("rst_after_latency", 32'(lat), 32'd8);
        chk("rst_after_product", 32'(product), 32'h003F);
        chk("rst_after_half", 32'(out_half), 32'h3F);
        @(posedge clk); #2;

        // Random back-to-back traffic against a scoreboard with random out_ready.
        sent = 0; n_acc = 0; n_hs = 0; cyc = 0;
        hold_v = 1'b0; hold_p = '0;
        in_valid = 1'b0;
        while ((sent < 1000 || n_hs < 1000) && cyc < 40000) begin
            if (in_valid) begin
                in_valid = 1'b0;
            end else if (in_ready && sent < 1000) begin
                a = 8'($urandom); b = 8'($urandom);
                hi_sel = 1'($urandom); signed_mode = 1'($urandom);
                in_valid = 1'b1;
                sent++;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (hold_v && out_valid)
                chk("rand_hold_product", 32'(product), 32'(hold_p));
            if (in_valid && in_ready) begin
                ra = a; rb = b; rh = hi_sel; rs = signed_mode;
                rp = ref_prod(ra, rb, rs);
                sb.push_back('{rp, rh ? rp[15:8] : rp[7:0]});
                n_acc++;
            end
            if (out_valid && out_ready) begin
                n_hs++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rand_extra_result: product 0x%0h with no outstanding transaction", product);
                end else begin
                    e = sb.pop_front();
                    chk("rand_product", 32'(product), 32'(e.prod));
                    chk("rand_out_half", 32'(out_half), 32'(e.half));
                end
            end
            hold_v = out_valid && !out_ready;
            hold_p = product;
            @(posedge clk); #2;
            cyc++;
        end
        chk("rand_accepted", 32'(n_acc), 32'd1000);
        chk("rand_delivered", 32'(n_hs), 32'd1000);
        chk("rand_outstanding", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
